// File: rtl/gpio_serial_loader.sv
// Loads per-pad configuration words into the two user-area pad control chains,
// shifting both chains in parallel MSB first, then strobing a common load.
module gpio_serial_loader #(
  parameter int AREA1PADS  = 19,
  parameter int TOTAL_PADS = 38,
  parameter int CFG_BITS   = 13,
  parameter int AW         = $clog2(TOTAL_PADS)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic [AW-1:0]       cfg_addr_1,
  input  logic [CFG_BITS-1:0] cfg_data_1,
  output logic [AW-1:0]       cfg_addr_2,
  input  logic [CFG_BITS-1:0] cfg_data_2,
  output logic                serial_clock,
  output logic                serial_data_1,
  output logic                serial_data_2,
  output logic                serial_load,
  output logic                busy,
  output logic                done
);

  localparam int N1   = AREA1PADS;
  localparam int N2   = TOTAL_PADS - AREA1PADS;
  localparam int S    = (N1 > N2) ? N1 : N2;
  localparam int PAD1 = S - N1;
  localparam int PAD2 = S - N2;
  localparam int KW   = (S > 1) ? $clog2(S) : 1;
  localparam int BW   = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  typedef enum logic [2:0] {IDLE, F0, F1, SLO, SHI, LOAD} state_t;

  state_t              state_reg, state_next;
  logic [KW-1:0]       k_reg, k_next;
  logic [BW-1:0]       bit_reg, bit_next;
  logic [CFG_BITS-1:0] sr1_reg, sr1_next, sr2_reg, sr2_next;
  logic [AW-1:0]       addr1_reg, addr1_next, addr2_reg, addr2_next;
  logic                done_reg, done_next;
  logic                pad_step_1, pad_step_2;

  // Chain 1 is walked from its highest pad down so pad 0 ends up shifted last;
  // the shorter chain is front-padded so both finish on the same step.
  function automatic logic [AW-1:0] addr_1_of(input logic [KW-1:0] k);
    logic [AW-1:0] a;
    if (int'(k) < PAD1) a = '0;
    else                a = AW'(N1 - 1 - (int'(k) - PAD1));
    return a;
  endfunction

  function automatic logic [AW-1:0] addr_2_of(input logic [KW-1:0] k);
    logic [AW-1:0] a;
    if (int'(k) < PAD2) a = '0;
    else                a = AW'(AREA1PADS + (int'(k) - PAD2));
    return a;
  endfunction

  assign pad_step_1 = int'(k_reg) < PAD1;
  assign pad_step_2 = int'(k_reg) < PAD2;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      bit_reg   <= '0;
      sr1_reg   <= '0;
      sr2_reg   <= '0;
      addr1_reg <= '0;
      addr2_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      bit_reg   <= bit_next;
      sr1_reg   <= sr1_next;
      sr2_reg   <= sr2_next;
      addr1_reg <= addr1_next;
      addr2_reg <= addr2_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    bit_next   = bit_reg;
    sr1_next   = sr1_reg;
    sr2_next   = sr2_reg;
    addr1_next = addr1_reg;
    addr2_next = addr2_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = F0;
          k_next     = '0;
          addr1_next = addr_1_of('0);
          addr2_next = addr_2_of('0);
        end
      end
      F0: state_next = F1;
      F1: begin
        sr1_next   = pad_step_1 ? '0 : cfg_data_1;
        sr2_next   = pad_step_2 ? '0 : cfg_data_2;
        bit_next   = BW'(CFG_BITS - 1);
        state_next = SLO;
      end
      SLO: state_next = SHI;
      SHI: begin
        sr1_next = sr1_reg << 1;
        sr2_next = sr2_reg << 1;
        if (bit_reg != '0) begin
          bit_next   = bit_reg - BW'(1);
          state_next = SLO;
        end else if (int'(k_reg) < S - 1) begin
          k_next     = k_reg + KW'(1);
          addr1_next = addr_1_of(k_reg + KW'(1));
          addr2_next = addr_2_of(k_reg + KW'(1));
          state_next = F0;
        end else begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Data is presented in SLO and held through SHI, so it only moves while serial_clock is low.
  assign serial_clock  = (state_reg == SHI);
  assign serial_load   = (state_reg == LOAD);
  assign serial_data_1 = ((state_reg == SLO) || (state_reg == SHI)) && sr1_reg[CFG_BITS-1];
  assign serial_data_2 = ((state_reg == SLO) || (state_reg == SHI)) && sr2_reg[CFG_BITS-1];
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign cfg_addr_1    = addr1_reg;
  assign cfg_addr_2    = addr2_reg;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: two instances (19/19 and 18/20 chain split),
// scoreboard of started transfers checked against chain models at each load.
module tb_gpio_serial_loader;

  localparam int TP   = 38;
  localparam int CB   = 13;
  localparam int AW   = 6;
  localparam int STEP = 2 + 2 * CB;

  typedef struct packed {
    int              start;
    logic [1:0]      mask;
    logic [TP*CB-1:0] snap;
  } txn_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          resetn;
  logic          start [2];
  logic [AW-1:0] cfg_addr_1 [2];
  logic [AW-1:0] cfg_addr_2 [2];
  logic [CB-1:0] cfg_data_1 [2];
  logic [CB-1:0] cfg_data_2 [2];
  logic          serial_clock [2];
  logic          serial_data_1 [2];
  logic          serial_data_2 [2];
  logic          serial_load [2];
  logic          busy [2];
  logic          done [2];
  logic [CB-1:0] rf [TP];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  txn_t sbq [$];
  int   hd [2] = '{0, 0};
  int   exp_loads [2] = '{0, 0};
  int   loads [2] = '{0, 0};
  int   dones [2] = '{0, 0};
  int   done_exp [2] = '{-1, -1};
  int   zero_exp [2] = '{-1, -1};
  int   bitcnt [2] = '{0, 0};
  int   wordcnt [2] = '{0, 0};
  logic sc_prev [2] = '{1'b0, 1'b0};
  logic sd1_prev [2] = '{1'b0, 1'b0};
  logic sd2_prev [2] = '{1'b0, 1'b0};
  logic [CB-1:0] acc1 [2] = '{default: '0};
  logic [CB-1:0] acc2 [2] = '{default: '0};
  logic [TP*CB-1:0] chain1 [2] = '{default: '1};
  logic [TP*CB-1:0] chain2 [2] = '{default: '1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      gpio_serial_loader #(
        .AREA1PADS  (gi == 0 ? 19 : 18),
        .TOTAL_PADS (TP),
        .CFG_BITS   (CB)
      ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start[gi]),
        .cfg_addr_1    (cfg_addr_1[gi]),
        .cfg_data_1    (cfg_data_1[gi]),
        .cfg_addr_2    (cfg_addr_2[gi]),
        .cfg_data_2    (cfg_data_2[gi]),
        .serial_clock  (serial_clock[gi]),
        .serial_data_1 (serial_data_1[gi]),
        .serial_data_2 (serial_data_2[gi]),
        .serial_load   (serial_load[gi]),
        .busy          (busy[gi]),
        .done          (done[gi])
      );
    end
  endgenerate

  always @(posedge clock) cyc <= cyc + 1;

  // Register file with one-cycle read latency on both ports.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      cfg_data_1[i] <= (int'(cfg_addr_1[i]) < TP) ? rf[cfg_addr_1[i]] : '0;
      cfg_data_2[i] <= (int'(cfg_addr_2[i]) < TP) ? rf[cfg_addr_2[i]] : '0;
    end
  end

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d: got 0x%0h, expected 0x%0h", nm, i, cyc, act, exp);
    end
  endtask

  // Pad sent on a chain at step k; -1 means a zero padding word, -2 a step that should not exist.
  function automatic int pad1_of(input int n1, input int s, input int k);
    if (k < s - n1) return -1;
    if (k >= s) return -2;
    return n1 - 1 - (k - (s - n1));
  endfunction

  function automatic int pad2_of(input int n1, input int s, input int k);
    int n2;
    n2 = TP - n1;
    if (k < s - n2) return -1;
    if (k >= s) return -2;
    return n1 + (k - (s - n2));
  endfunction

  task automatic mon(input int i);
    int   n1, n2, s, p1, p2, bad1, bad2;
    logic rise, pending;
    txn_t t;
    n1 = (i == 0) ? 19 : 18;
    n2 = TP - n1;
    s  = (n1 > n2) ? n1 : n2;
    rise = serial_clock[i] && !sc_prev[i];
    t = '0;
    if (!resetn) begin
      hd[i] = sbq.size();
      bitcnt[i] = 0;
      wordcnt[i] = 0;
      done_exp[i] = -1;
      zero_exp[i] = cyc + 1;
    end else begin
      while (hd[i] < sbq.size() && !sbq[hd[i]].mask[i]) hd[i]++;
      pending = hd[i] < sbq.size();
      if (pending) t = sbq[hd[i]];
      if (cyc == zero_exp[i])
        chk("post_reset_outputs", i, int'({busy[i], done[i], serial_load[i], serial_clock[i],
            serial_data_1[i], serial_data_2[i], cfg_addr_1[i], cfg_addr_2[i]}), 0);
      chk("busy_done_exclusive", i, int'(busy[i] && done[i]), 0);
      chk("load_with_sclk_high", i, int'(serial_load[i] && serial_clock[i]), 0);
      chk("data_stable_sclk_high", i, serial_clock[i] ?
          int'({serial_data_1[i], serial_data_2[i]} != {sd1_prev[i], sd2_prev[i]}) : 0, 0);
      chk("idle_outputs", i, busy[i] ? 0 :
          int'({serial_clock[i], serial_load[i], serial_data_1[i], serial_data_2[i]}), 0);
      if (!pending) begin
        chk("no_shift_when_idle", i, int'(rise), 0);
        chk("no_load_when_idle", i, int'(serial_load[i]), 0);
      end else begin
        if (cyc == t.start + 1) chk("busy_after_start", i, int'(busy[i]), 1);
        if (rise) begin
          p1 = pad1_of(n1, s, wordcnt[i]);
          p2 = pad2_of(n1, s, wordcnt[i]);
          if (bitcnt[i] == 0) begin
            chk("cfg_addr_1", i, int'(cfg_addr_1[i]), (p1 == -1) ? 0 : p1);
            chk("cfg_addr_2", i, int'(cfg_addr_2[i]), (p2 == -1) ? 0 : p2);
          end
          acc1[i] = {acc1[i][CB-2:0], serial_data_1[i]};
          acc2[i] = {acc2[i][CB-2:0], serial_data_2[i]};
          chain1[i] = {chain1[i][TP*CB-2:0], serial_data_1[i]};
          chain2[i] = {chain2[i][TP*CB-2:0], serial_data_2[i]};
          bitcnt[i]++;
          if (bitcnt[i] == CB) begin
            chk("word_1", i, int'(acc1[i]), (p1 >= 0) ? int'(t.snap[p1*CB +: CB]) : 0);
            chk("word_2", i, int'(acc2[i]), (p2 >= 0) ? int'(t.snap[p2*CB +: CB]) : 0);
            bitcnt[i] = 0;
            wordcnt[i]++;
          end
        end
        if (serial_load[i]) begin
          chk("load_cycle", i, cyc, t.start + 1 + s * STEP);
          chk("bits_shifted", i, wordcnt[i] * CB + bitcnt[i], s * CB);
          bad1 = 0;
          bad2 = 0;
          for (int p = 0; p < n1; p++)
            if (chain1[i][p*CB +: CB] !== t.snap[p*CB +: CB]) bad1++;
          for (int q = 0; q < n2; q++)
            if (chain2[i][q*CB +: CB] !== t.snap[(TP-1-q)*CB +: CB]) bad2++;
          chk("chain_1_bad_pads", i, bad1, 0);
          chk("chain_2_bad_pads", i, bad2, 0);
          loads[i]++;
          hd[i]++;
          done_exp[i] = cyc + 1;
          wordcnt[i] = 0;
          bitcnt[i] = 0;
        end else begin
          chk("transfer_deadline", i, int'(cyc <= t.start + 2 + s * STEP), 1);
          if (cyc > t.start + 2 + s * STEP) hd[i]++;
        end
      end
      if (done[i] || cyc == done_exp[i]) begin
        chk("done_pulse", i, int'(done[i]), int'(cyc == done_exp[i]));
        if (done[i]) dones[i]++;
      end
    end
    sc_prev[i]  = serial_clock[i];
    sd1_prev[i] = serial_data_1[i];
    sd2_prev[i] = serial_data_2[i];
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) mon(i);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] mask);
    txn_t t;
    t.start = cyc;
    t.mask  = mask;
    for (int p = 0; p < TP; p++) t.snap[p*CB +: CB] = rf[p];
    sbq.push_back(t);
    for (int i = 0; i < 2; i++) if (mask[i]) exp_loads[i]++;
  endtask

  task automatic go(input logic [1:0] mask);
    start[0] = mask[0];
    start[1] = mask[1];
    push(mask);
    tick();
    start[0] = 1'b0;
    start[1] = 1'b0;
  endtask

  task automatic poke_ignored(input int at);
    while (cyc < at) tick();
    start[0] = 1'b1;
    start[1] = 1'b1;
    tick();
    start[0] = 1'b0;
    start[1] = 1'b0;
  endtask

  task automatic randomize_rf();
    for (int p = 0; p < TP; p++) rf[p] = CB'($urandom & 32'h1FFF);
  endtask

  initial begin
    int c0;
    logic [1:0] restarted;
    resetn = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    for (int p = 0; p < TP; p++) rf[p] = CB'((p * 32'h101) & 32'h1FFF);
    repeat (3) tick();
    resetn = 1'b1;

    // Fixed pattern, with starts during the transfer that must be ignored.
    c0 = cyc;
    go(2'b11);
    poke_ignored(c0 + 100);
    poke_ignored(c0 + 300);
    while (cyc < c0 + 2 + 20 * STEP + 4) tick();

    repeat (3) begin
      randomize_rf();
      c0 = cyc;
      go(2'b11);
      poke_ignored(c0 + int'($urandom_range(5, 500)));
      while (cyc < c0 + 2 + 20 * STEP + 4) tick();
    end

    // Restart each instance in the very cycle its done pulse is high.
    randomize_rf();
    go(2'b11);
    restarted = 2'b00;
    for (int n = 0; n < 2000 && restarted != 2'b11; n++) begin
      tick();
      start[0] = 1'b0;
      start[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (done[i] && !restarted[i]) begin
          start[i] = 1'b1;
          push(2'(1 << i));
          restarted[i] = 1'b1;
        end
      end
    end
    tick();
    start[0] = 1'b0;
    start[1] = 1'b0;
    chk("b2b_done_seen", 0, int'(restarted), 3);
    repeat (2 + 20 * STEP + 6) tick();

    // Reset pulse during the first SHI of step 5 aborts both transfers.
    randomize_rf();
    c0 = cyc;
    go(2'b11);
    while (cyc < c0 + 1 + 5 * STEP + 3) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_loads[0]--;
    exp_loads[1]--;
    repeat (40) tick();
    randomize_rf();
    c0 = cyc;
    go(2'b11);
    while (cyc < c0 + 2 + 20 * STEP + 4) tick();

    for (int i = 0; i < 2; i++) begin
      chk("load_count", i, loads[i], exp_loads[i]);
      chk("done_count", i, dones[i], exp_loads[i]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
